sr_delay_buf: RTL and testbench

Delay-line buffer that sits directly upstream of the radix-2 butterfly in the streaming FFT. Each cycle it takes a 16-sample complex beat. It stores the first DEPTH beats of every 2×DEPTH-beat block. During the next DEPTH beats it presents each stored beat together with the live beat as a registered (sr, org) pair. This pair is exactly what the butterfly needs to combine x[n] with x[n+DEPTH·UNIT_SIZE].

---
 rtl/sr_delay_buf.sv | 136 +++++++++++++
 tb/tb_sr_delay_buf.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_delay_buf.sv
`default_nettype none
// ----------------------------------------------------------------------------
// sr_delay_buf : delay-line buffer that pairs beat n with beat n+DEPTH for the
//                radix-2 butterfly. Optional flush input: SR_DELAY_BUF_FLUSH_EN.
// Revision     : 1.0
// ----------------------------------------------------------------------------
module sr_delay_buf #(
  parameter int DATA_W    = 9,
  parameter int UNIT_SIZE = 16,
  parameter int DEPTH     = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
`ifdef SR_DELAY_BUF_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     din_valid,
  input  logic signed [DATA_W-1:0] din_real [0:UNIT_SIZE-1],
  input  logic signed [DATA_W-1:0] din_imag [0:UNIT_SIZE-1],
  output logic                     valid_out,
  output logic signed [DATA_W-1:0] sr_real  [0:UNIT_SIZE-1],
  output logic signed [DATA_W-1:0] sr_imag  [0:UNIT_SIZE-1],
  output logic signed [DATA_W-1:0] org_real [0:UNIT_SIZE-1],
  output logic signed [DATA_W-1:0] org_imag [0:UNIT_SIZE-1],
  output logic [$clog2(DEPTH)-1:0] pair_idx,
  output logic                     block_done
);

  localparam int               CNT_W    = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PAIR = 1'b1
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] wr_cnt;
  logic [CNT_W-1:0] wr_cnt_d;
  logic             flush_req;
  logic             mem_we;
  logic             pair_fire;
  logic             cnt_last;

  logic signed [DATA_W-1:0] mem_real [0:DEPTH-1][0:UNIT_SIZE-1];
  logic signed [DATA_W-1:0] mem_imag [0:DEPTH-1][0:UNIT_SIZE-1];

`ifdef SR_DELAY_BUF_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign cnt_last = (wr_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FILL;
      wr_cnt  <= '0;
    end else begin
      state_q <= state_d;
      wr_cnt  <= wr_cnt_d;
    end
  end

  // Flush wins over din_valid; idle cycles freeze state and counter.
  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt;
    mem_we    = 1'b0;
    pair_fire = 1'b0;
    if (flush_req) begin
      state_d  = FILL;
      wr_cnt_d = '0;
    end else if (din_valid) begin
      wr_cnt_d = cnt_last ? '0 : wr_cnt + 1'b1;
      case (state_q)
        FILL: begin
          mem_we = 1'b1;
          if (cnt_last) state_d = PAIR;
        end
        PAIR: begin
          pair_fire = 1'b1;
          if (cnt_last) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int d = 0; d < DEPTH; d++) begin
        for (int k = 0; k < UNIT_SIZE; k++) begin
          mem_real[d][k] <= '0;
          mem_imag[d][k] <= '0;
        end
      end
    end else if (mem_we) begin
      for (int k = 0; k < UNIT_SIZE; k++) begin
        mem_real[wr_cnt][k] <= din_real[k];
        mem_imag[wr_cnt][k] <= din_imag[k];
      end
    end
  end

  // Pair data and index hold their last values while valid_out is low.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out  <= 1'b0;
      block_done <= 1'b0;
      pair_idx   <= '0;
      for (int k = 0; k < UNIT_SIZE; k++) begin
        sr_real[k]  <= '0;
        sr_imag[k]  <= '0;
        org_real[k] <= '0;
        org_imag[k] <= '0;
      end
    end else begin
      valid_out  <= pair_fire;
      block_done <= pair_fire & cnt_last;
      if (pair_fire) begin
        pair_idx <= wr_cnt;
        for (int k = 0; k < UNIT_SIZE; k++) begin
          sr_real[k]  <= mem_real[wr_cnt][k];
          sr_imag[k]  <= mem_imag[wr_cnt][k];
          org_real[k] <= din_real[k];
          org_imag[k] <= din_imag[k];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sr_delay_buf.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_sr_delay_buf : scoreboard bench for sr_delay_buf (DEPTH=16, DATA_W=9).
// Revision        : 1.0
// ----------------------------------------------------------------------------
module tb_sr_delay_buf;

  localparam int W  = 9;
  localparam int U  = 16;
  localparam int D  = 16;
  localparam int IW = $clog2(D);

  typedef logic [U-1:0][W-1:0] pbeat_t;

  typedef struct packed {
    pbeat_t          sr_r;
    pbeat_t          sr_i;
    pbeat_t          org_r;
    pbeat_t          org_i;
    logic [IW-1:0]   idx;
    logic            done;
  } exp_t;

  typedef struct packed {
    int nbeats;
    int gap;
    int base;
    int exp_pairs;
    int exp_dones;
  } scen_t;

  logic                clk = 1'b0;
  logic                rstn = 1'b0;
  logic                flush = 1'b0;
  logic                din_valid = 1'b0;
  logic signed [W-1:0] din_real [0:U-1];
  logic signed [W-1:0] din_imag [0:U-1];
  logic                valid_out;
  logic signed [W-1:0] sr_real  [0:U-1];
  logic signed [W-1:0] sr_imag  [0:U-1];
  logic signed [W-1:0] org_real [0:U-1];
  logic signed [W-1:0] org_imag [0:U-1];
  logic [IW-1:0]       pair_idx;
  logic                block_done;

  sr_delay_buf #(.DATA_W(W), .UNIT_SIZE(U), .DEPTH(D)) dut (
    .clk        (clk),
    .rstn       (rstn),
`ifdef SR_DELAY_BUF_FLUSH_EN
    .flush      (flush),
`endif
    .din_valid  (din_valid),
    .din_real   (din_real),
    .din_imag   (din_imag),
    .valid_out  (valid_out),
    .sr_real    (sr_real),
    .sr_imag    (sr_imag),
    .org_real   (org_real),
    .org_imag   (org_imag),
    .pair_idx   (pair_idx),
    .block_done (block_done)
  );

  always #5 clk = ~clk;

  int     total = 0;
  int     bad = 0;
  int     n_beats = 0;
  int     pairs_seen = 0;
  int     dones_seen = 0;
  exp_t   q[$];
  exp_t   last;
  pbeat_t hist_r [0:D-1];
  pbeat_t hist_i [0:D-1];
  pbeat_t o_sr_r, o_sr_i, o_org_r, o_org_i;
  scen_t  scen [0:4];

  task automatic chk(input string name, input logic [U*W-1:0] act, input logic [U*W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic pbeat_t splat(input int v);
    pbeat_t b;
    for (int k = 0; k < U; k++) b[k] = W'(v);
    return b;
  endfunction

  function automatic pbeat_t rnd_beat();
    pbeat_t b;
    for (int k = 0; k < U; k++) b[k] = W'($urandom);
    return b;
  endfunction

  task automatic sample_outputs();
    for (int k = 0; k < U; k++) begin
      o_sr_r[k]  = sr_real[k];
      o_sr_i[k]  = sr_imag[k];
      o_org_r[k] = org_real[k];
      o_org_i[k] = org_imag[k];
    end
  endtask

  // Expected pair for beat n: position p in the 2*D block; p>=D pairs with p-D.
  task automatic drive(input bit v, input pbeat_t r, input pbeat_t i, input bit fl);
    bit   exp_v;
    exp_t e;
    int   p;
    @(negedge clk);
    din_valid = v;
    flush     = fl;
    for (int k = 0; k < U; k++) begin
      din_real[k] = r[k];
      din_imag[k] = i[k];
    end
    exp_v = 1'b0;
    if (fl) begin
      n_beats = 0;
    end else if (v) begin
      p = n_beats % (2 * D);
      if (p < D) begin
        hist_r[p] = r;
        hist_i[p] = i;
      end else begin
        e.sr_r  = hist_r[p-D];
        e.sr_i  = hist_i[p-D];
        e.org_r = r;
        e.org_i = i;
        e.idx   = IW'(p - D);
        e.done  = (p == 2 * D - 1);
        q.push_back(e);
        exp_v = 1'b1;
      end
      n_beats++;
    end
    @(posedge clk);
    #1;
    sample_outputs();
    chk("valid_out", valid_out, exp_v);
    if (exp_v && q.size() > 0) last = q.pop_front();
    chk("block_done", block_done, exp_v ? last.done : 1'b0);
    chk("sr_real", o_sr_r, last.sr_r);
    chk("sr_imag", o_sr_i, last.sr_i);
    chk("org_real", o_org_r, last.org_r);
    chk("org_imag", o_org_i, last.org_i);
    chk("pair_idx", pair_idx, last.idx);
    if (valid_out) pairs_seen++;
    if (block_done) dones_seen++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    din_valid = 1'b0;
    flush     = 1'b0;
    #2;
    sample_outputs();
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_done", block_done, 1'b0);
    chk("rst_idx", pair_idx, '0);
    chk("rst_sr_real", o_sr_r, '0);
    chk("rst_sr_imag", o_sr_i, '0);
    chk("rst_org_real", o_org_r, '0);
    chk("rst_org_imag", o_org_i, '0);
    @(negedge clk);
    rstn = 1'b1;
    n_beats = 0;
    last    = '0;
    q.delete();
  endtask

  task automatic run_scen(input scen_t s);
    int  sent;
    int  cyc;
    bit  v;
    do_reset();
    pairs_seen = 0;
    dones_seen = 0;
    sent = 0;
    cyc  = 0;
    while (sent < s.nbeats) begin
      case (s.gap)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (!v)             drive(1'b0, rnd_beat(), rnd_beat(), 1'b0);
      else if (s.gap > 1) drive(1'b1, rnd_beat(), rnd_beat(), 1'b0);
      else                drive(1'b1, splat(s.base + sent), splat(-(s.base + sent)), 1'b0);
      if (v) sent++;
      cyc++;
    end
    for (int t = 0; t < 3; t++) drive(1'b0, rnd_beat(), rnd_beat(), 1'b0);
    chk("scen_pairs", pairs_seen, s.exp_pairs);
    chk("scen_dones", dones_seen, s.exp_dones);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < U; k++) begin
      din_real[k] = '0;
      din_imag[k] = '0;
    end
    last = '0;
    //            nbeats gap base pairs dones
    scen[0] = '{32, 0, 0,   16, 1};
    scen[1] = '{64, 0, 0,   32, 2};
    scen[2] = '{32, 1, 0,   16, 1};
    scen[3] = '{48, 2, 0,   16, 1};
    scen[4] = '{40, 1, 200, 16, 1};
    for (int s = 0; s < 5; s++) run_scen(scen[s]);

    // Reset mid-block, then a fresh block must not expose stale data.
    do_reset();
    for (int n = 0; n < 20; n++) drive(1'b1, splat(n), splat(-n), 1'b0);
    do_reset();
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, splat(100 + n), splat(-(100 + n)), 1'b0);
      if (n == 16) begin
        chk("rst_first_sr", $unsigned(sr_real[0]), 9'd100);
        chk("rst_first_org", $unsigned(org_real[0]), 9'd116);
      end
    end

    // Extreme sample values on beat 0.
    do_reset();
    drive(1'b1, splat(255), splat(-256), 1'b0);
    for (int n = 1; n < 32; n++) begin
      drive(1'b1, splat(n), splat(-n), 1'b0);
      if (n == 16) begin
        chk("bound_sr_real", $unsigned(sr_real[0]), 9'h0FF);
        chk("bound_sr_imag", $unsigned(sr_imag[0]), 9'h100);
      end
    end

`ifdef SR_DELAY_BUF_FLUSH_EN
    do_reset();
    for (int n = 0; n < 20; n++) drive(1'b1, splat(n), splat(-n), 1'b0);
    drive(1'b1, splat(77), splat(-77), 1'b1);
    chk("flush_valid", valid_out, 1'b0);
    for (int n = 0; n < 32; n++) begin
      drive(1'b1, splat(50 + n), splat(-(50 + n)), 1'b0);
      if (n == 16) chk("flush_first_sr", $unsigned(sr_real[0]), 9'd50);
    end
    flush = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
